expr_eval: RTL and testbench
============================

Name: expr_eval

Overview:
- Character-serial arithmetic evaluator. It is the stage directly downstream of the expression-syntax recognizer and consumes the same 8-bit ASCII stream, one character per accepted cycle.
- Grammar: single decimal digits, binary '+' and '*', and one level of parentheses. A parenthesised group holds one or more digit terms.
- Computes the running value with '*' binding tighter than '+'. Flags a sticky error on the first illegal character.
- Feeds the result/accept pair to the downstream consumer of the recognizer's accept flag.

Parameters:
- W, 16, width of all arithmetic registers and of result. All arithmetic is modulo 2^W.

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_char is consumed on this clk edge only when in_valid=1
- in_char  in  8  ASCII character
- valid  out  1  expression consumed so far is complete and legal (ends in a digit or ')' at outer level)
- result  out  W  value of the complete expression; meaningful when valid=1
- err  out  1  sticky syntax error

Behaviour:
- Reset (clr=1, any time, async):
  - state=S_START; outer sum=0, outer prod=1; inner sum=0, inner prod=1.
  - valid=0, result=0, err=0.
- Cycles with in_valid=0 change nothing; all outputs hold.
- Character classes:
  - DIG: '0'..'9', value = in_char-8'h30, zero-extended to W.
  - OP: '+' or '*'.
  - LP: '('.
  - RP: ')'.
  - Anything else, including space and NUL, is illegal.
- States and transitions (unlisted class goes to S_ERR):
  - S_START: DIG->S_NUM; LP->S_LPAR.
  - S_NUM: OP->S_OP.
  - S_OP: DIG->S_NUM; LP->S_LPAR.
  - S_LPAR: DIG->S_INUM.
  - S_INUM: RP->S_RPAR; OP->S_IOP.
  - S_RPAR: OP->S_OP.
  - S_IOP: DIG->S_INUM.
  - S_ERR: absorbing; only clr leaves it.
- Accumulator rules. Each level (outer, inner) keeps sum and prod.
  - Operand v: prod <= prod*v.
  - '+': sum <= sum+prod, then prod <= 1.
  - '*': no register change; the next operand multiplies into prod.
  - Level value = sum+prod.
  - All products and sums are truncated to W bits.
- Outer level:
  - Operands are DIG in S_START/S_OP, and the inner value on RP.
  - OP in S_NUM/S_RPAR updates the outer accumulator.
- Inner level:
  - LP clears inner sum=0 and prod=1.
  - DIG in S_LPAR/S_IOP is an inner operand.
  - OP in S_INUM updates the inner accumulator.
  - RP applies inner sum+prod as an outer operand in the same edge.
- Outputs are registered. The character consumed at edge k is reflected after edge k; latency is 1 edge.
  - valid=1 exactly when state is S_NUM or S_RPAR.
  - result is loaded with the post-update outer sum+prod on every edge that enters S_NUM or S_RPAR. It holds otherwise.
  - While valid=0 (mid-expression), result shows the last complete value.
- Error:
  - The illegal character sets err=1 and forces valid=0 on the same edge.
  - result holds its last value and the accumulators freeze.
  - err stays 1 until clr.
- clr mid-expression aborts the expression; the next character starts a new expression.
- Overflow: silent wrap, no flag.

Decomposition:
- Shared package expr_pkg holds:
  - ASCII constants CH_0, CH_9, CH_PLUS, CH_STAR, CH_LP, CH_RP.
  - State enum (8 codes, 3 bits).
  - Class-decode function.
- One sub-module, term_acc (parameter W). It holds one sum/prod pair with three inputs:
  - op_operand (with a W-bit operand value)
  - op_plus
  - op_init
- term_acc outputs the level value. It is instantiated twice, once for the outer level and once for the inner level.

Test Plan:
- "1+2*3" streamed back-to-back -> valid=1 after '1' (result=1), 0 after '+', 1 after '2' (result=3), 0 after '*', 1 after '3' with result=7; err=0 throughout.
- "2*(3+4*5)+1" -> valid=0 inside parentheses; result=46 after ')'; result=47 after the final '1'.
- W=8, "9*9*9*9" -> result=161 (6561 mod 256); no error.
- "(1+2)*3" with in_valid=0 for 2 cycles between every character -> outputs hold during gaps; final result=9, valid=1.
- "1++2" -> err=1 and valid=0 after the second '+'; result stays 1; the following '2' has no effect; err remains set.
- "7*(" then clr asserted between clock edges -> valid, result and err drop to 0 immediately; "5" then gives result=5, valid=1.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants, state encoding and character-class decode for expr_eval.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_LP   = 8'h28;
  localparam logic [7:0] CH_RP   = 8'h29;

  typedef enum logic [2:0] {
    S_START, S_NUM, S_OP, S_LPAR, S_INUM, S_RPAR, S_IOP, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    C_DIG, C_OP, C_LP, C_RP, C_BAD
  } cls_t;

  // Anything that is not a digit, operator or parenthesis is illegal.
  function automatic cls_t char_class(input logic [7:0] c);
    if (c >= CH_0 && c <= CH_9)            return C_DIG;
    else if (c == CH_PLUS || c == CH_STAR) return C_OP;
    else if (c == CH_LP)                   return C_LP;
    else if (c == CH_RP)                   return C_RP;
    else                                   return C_BAD;
  endfunction

endpackage

// File: rtl/expr_eval_term_acc.sv
// One precedence level: running sum of completed terms plus the product of the open term.
// Latency: registers update on the edge; value is the post-update level value (combinational).
// Backpressure: none; the op_* strobes are only raised on accepted characters.
module term_acc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         op_init,
  input  logic         op_plus,
  input  logic         op_operand,
  input  logic [W-1:0] operand,
  output logic [W-1:0] value
);

  logic [W-1:0] sum, prod, sum_nxt, prod_nxt;

  // Next-value select; init wins over '+', which wins over an operand.
  always_comb begin
    sum_nxt  = sum;
    prod_nxt = prod;
    if (op_init) begin
      sum_nxt  = '0;
      prod_nxt = W'(1);
    end else if (op_plus) begin
      sum_nxt  = sum + prod;
      prod_nxt = W'(1);
    end else if (op_operand) begin
      prod_nxt = prod * operand;
    end
  end

  // Accumulator registers; reset to the empty-level identity (0 + 1).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum  <= '0;
      prod <= W'(1);
    end else begin
      sum  <= sum_nxt;
      prod <= prod_nxt;
    end
  end

  // With no strobe raised this is simply the current sum+prod.
  assign value = sum_nxt + prod_nxt;

endmodule

// File: rtl/expr_eval.sv
// Character-serial evaluator of digit/+/* expressions with one level of parentheses.
// Latency: 1 edge from an accepted character to valid/result/err.
// Backpressure: none; every in_valid cycle is consumed, in_valid=0 cycles hold all state.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in_char,
  output logic         valid,
  output logic [W-1:0] result,
  output logic         err
);

  state_t       state, state_nxt;
  cls_t         cls;
  logic [W-1:0] dig, out_operand, out_val, in_val;
  logic         out_op, out_plus, in_init, in_op, in_plus;
  logic         done_nxt;

  assign cls = char_class(in_char);
  assign dig = W'(in_char - CH_0);

  // Next state and accumulator strobes; an unlisted class in any state lands in S_ERR,
  // and no strobe fires on that edge so both levels freeze.
  always_comb begin
    state_nxt   = state;
    out_op      = 1'b0;
    out_plus    = 1'b0;
    out_operand = dig;
    in_init     = 1'b0;
    in_op       = 1'b0;
    in_plus     = 1'b0;
    if (in_valid) begin
      state_nxt = S_ERR;
      case (state)
        S_START, S_OP: begin
          if (cls == C_DIG) begin
            state_nxt = S_NUM;
            out_op    = 1'b1;
          end else if (cls == C_LP) begin
            state_nxt = S_LPAR;
            in_init   = 1'b1;
          end
        end
        S_NUM, S_RPAR: begin
          if (cls == C_OP) begin
            state_nxt = S_OP;
            out_plus  = (in_char == CH_PLUS);
          end
        end
        S_LPAR, S_IOP: begin
          if (cls == C_DIG) begin
            state_nxt = S_INUM;
            in_op     = 1'b1;
          end
        end
        S_INUM: begin
          if (cls == C_RP) begin
            // The closed group multiplies into the outer term on this same edge.
            state_nxt   = S_RPAR;
            out_op      = 1'b1;
            out_operand = in_val;
          end else if (cls == C_OP) begin
            state_nxt = S_IOP;
            in_plus   = (in_char == CH_PLUS);
          end
        end
        default: state_nxt = S_ERR;
      endcase
    end
  end

  assign done_nxt = (state_nxt == S_NUM) || (state_nxt == S_RPAR);

  term_acc #(.W(W)) u_outer (
    .clk        (clk),
    .clr        (clr),
    .op_init    (1'b0),
    .op_plus    (out_plus),
    .op_operand (out_op),
    .operand    (out_operand),
    .value      (out_val)
  );

  term_acc #(.W(W)) u_inner (
    .clk        (clk),
    .clr        (clr),
    .op_init    (in_init),
    .op_plus    (in_plus),
    .op_operand (in_op),
    .operand    (dig),
    .value      (in_val)
  );

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_START;
    else     state <= state_nxt;
  end

  // Registered outputs; result only reloads when an accepted character completes an expression.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else if (in_valid) begin
      valid <= done_nxt;
      err   <= (state_nxt == S_ERR);
      if (done_nxt) result <= out_val;
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;

  typedef logic [7:0] chq_t[$];

  typedef struct {
    string text;
    bit    v;
    bit    e;
    int    r16;
    int    r8;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        valid16, err16, valid8, err8;
  logic [15:0] res16;
  logic [7:0]  res8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the legal characters accepted so far, plus the expected outputs.
  chq_t            mq;
  bit              m_err, m_valid;
  longint unsigned m_res;

  expr_eval #(.W(16)) u16 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
    .valid(valid16), .result(res16), .err(err16)
  );

  expr_eval #(.W(8)) u8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
    .valid(valid8), .result(res8), .err(err8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic bit is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic longint unsigned dval(input logic [7:0] c);
    return 64'(c) - 64'd48;
  endfunction

  function automatic int depth_of(input chq_t q);
    int d = 0;
    foreach (q[i]) begin
      if (q[i] == 8'h28) d++;
      if (q[i] == 8'h29) d--;
    end
    return d;
  endfunction

  // Grammar check: may character c follow the accepted text q?
  function automatic bit legal_next(input chq_t q, input logic [7:0] c);
    bit         has_p = (q.size() > 0);
    logic [7:0] p = has_p ? q[q.size()-1] : 8'h00;
    bit         after_op = has_p && (p == 8'h2B || p == 8'h2A);
    int         d = depth_of(q);
    if (is_dig(c))                  return !has_p || after_op || p == 8'h28;
    if (c == 8'h28)                 return d == 0 && (!has_p || after_op);
    if (c == 8'h29)                 return d == 1 && has_p && is_dig(p);
    if (c == 8'h2B || c == 8'h2A)   return has_p && (is_dig(p) || p == 8'h29);
    return 1'b0;
  endfunction

  function automatic bit complete(input chq_t q);
    if (q.size() == 0) return 1'b0;
    return depth_of(q) == 0 && (is_dig(q[q.size()-1]) || q[q.size()-1] == 8'h29);
  endfunction

  // Sum of products over q[lo..hi], which holds only digits and operators.
  function automatic longint unsigned eval_flat(input chq_t q, input int lo, input int hi);
    longint unsigned total = 0;
    int start = lo;
    for (int i = lo; i <= hi + 1; i++) begin
      if (i == hi + 1 || q[i] == 8'h2B) begin
        longint unsigned p = 1;
        for (int j = start; j < i; j++)
          if (is_dig(q[j])) p = p * dval(q[j]);
        total = total + p;
        start = i + 1;
      end
    end
    return total;
  endfunction

  // Split the whole text into top-level terms; each term is a product of digits and groups.
  function automatic longint unsigned eval_expr(input chq_t q);
    longint unsigned total = 0;
    int n = q.size();
    int start = 0;
    int d = 0;
    for (int i = 0; i <= n; i++) begin
      if (i == n || (q[i] == 8'h2B && d == 0)) begin
        longint unsigned p = 1;
        int j = start;
        while (j < i) begin
          if (q[j] == 8'h28) begin
            int k = j;
            while (k < i && q[k] != 8'h29) k++;
            p = p * eval_flat(q, j + 1, k - 1);
            j = k + 1;
          end else begin
            if (is_dig(q[j])) p = p * dval(q[j]);
            j++;
          end
        end
        total = total + p;
        start = i + 1;
      end else if (q[i] == 8'h28) d++;
      else if (q[i] == 8'h29) d--;
    end
    return total;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_res   = 0;
  endfunction

  function automatic void model_step(input logic [7:0] c);
    if (m_err) return;
    if (legal_next(mq, c)) begin
      mq.push_back(c);
      if (complete(mq)) begin
        m_valid = 1'b1;
        m_res   = eval_expr(mq);
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_err   = 1'b1;
      m_valid = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (time %0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " valid16"}, 64'(valid16), 64'(m_valid));
    check({tag, " err16"},   64'(err16),   64'(m_err));
    check({tag, " result16"}, 64'(res16),  64'(m_res[15:0]));
    check({tag, " valid8"},  64'(valid8),  64'(m_valid));
    check({tag, " err8"},    64'(err8),    64'(m_err));
    check({tag, " result8"}, 64'(res8),    64'(m_res[7:0]));
  endtask

  task automatic send(input logic [7:0] c);
    in_char  = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_step(c);
    check_model("step");
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Idle cycles with garbage on in_char; nothing may move.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_char = 8'h20;
      @(posedge clk);
      #1;
      check_model("hold");
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    model_reset();
    check_model("clr");
    #1;
    clr = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"1+2*3",           1'b1, 1'b0, 7,    7});
    vecs.push_back('{"2*(3+4*5)+1",     1'b1, 1'b0, 47,   47});
    vecs.push_back('{"9*9*9*9",         1'b1, 1'b0, 6561, 161});
    vecs.push_back('{"(1+2)*3",         1'b1, 1'b0, 9,    9});
    vecs.push_back('{"1++2",            1'b0, 1'b1, 1,    1});
    vecs.push_back('{"(9*9+9)*9*9*9",   1'b1, 1'b0, 74,   74});
    vecs.push_back('{"8*",              1'b0, 1'b0, 8,    8});
    vecs.push_back('{"()",              1'b0, 1'b1, 0,    0});
    vecs.push_back('{"(1)",             1'b1, 1'b0, 1,    1});
    vecs.push_back('{"1 ",              1'b0, 1'b1, 1,    1});
    vecs.push_back('{"5*(2)*(3+1)",     1'b1, 1'b0, 40,   40});
    vecs.push_back('{"((",              1'b0, 1'b1, 0,    0});
    vecs.push_back('{"3)",              1'b0, 1'b1, 3,    3});
    vecs.push_back('{"9+9*9+(9*9*9)*9", 1'b1, 1'b0, 6651, 251});
    vecs.push_back('{"2*(3+4)(",        1'b0, 1'b1, 14,   14});

    // Reset state.
    model_reset();
    #3;
    check("reset valid", 64'(valid16), 64'd0);
    check("reset err",   64'(err16),   64'd0);
    check("reset result", 64'(res16),  64'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Per-character walk through "1+2*3".
    send("1"); check("p1 valid", 64'(valid16), 64'd1); check("p1 result", 64'(res16), 64'd1);
    send("+"); check("p2 valid", 64'(valid16), 64'd0); check("p2 result", 64'(res16), 64'd1);
    send("2"); check("p3 valid", 64'(valid16), 64'd1); check("p3 result", 64'(res16), 64'd3);
    send("*"); check("p4 valid", 64'(valid16), 64'd0);
    send("3"); check("p5 valid", 64'(valid16), 64'd1); check("p5 result", 64'(res16), 64'd7);
    check("p5 err", 64'(err16), 64'd0);

    // Parenthesised group: hidden inside, applied on ')'.
    pulse_clr();
    send_str("2*(3+4*5");
    check("paren inside valid", 64'(valid16), 64'd0);
    check("paren inside result", 64'(res16), 64'd2);
    send(")"); check("paren close result", 64'(res16), 64'd46);
    send_str("+1"); check("paren final result", 64'(res16), 64'd47);

    // Two idle cycles between every character.
    pulse_clr();
    begin
      string s = "(1+2)*3";
      for (int i = 0; i < s.len(); i++) begin
        send(s[i]);
        gap(2);
      end
    end
    check("gap valid", 64'(valid16), 64'd1);
    check("gap result", 64'(res16), 64'd9);

    // Sticky error.
    pulse_clr();
    send_str("1++");
    check("err set", 64'(err16), 64'd1);
    check("err valid", 64'(valid16), 64'd0);
    check("err result", 64'(res16), 64'd1);
    send("2");
    check("err sticky", 64'(err16), 64'd1);
    check("err frozen", 64'(res16), 64'd1);

    // Asynchronous clear mid-expression.
    pulse_clr();
    send_str("7*(");
    clr = 1'b1;
    #1;
    check("aclr valid", 64'(valid16), 64'd0);
    check("aclr result", 64'(res16), 64'd0);
    check("aclr err", 64'(err16), 64'd0);
    model_reset();
    #1;
    clr = 1'b0;
    send("5");
    check("aclr restart valid", 64'(valid16), 64'd1);
    check("aclr restart result", 64'(res16), 64'd5);

    // Table of whole expressions with hand-computed final outputs.
    foreach (vecs[i]) begin
      pulse_clr();
      send_str(vecs[i].text);
      check({"vec ", vecs[i].text, " valid"},  64'(valid16), 64'(vecs[i].v));
      check({"vec ", vecs[i].text, " err"},    64'(err16),   64'(vecs[i].e));
      check({"vec ", vecs[i].text, " result"}, 64'(res16),   64'(vecs[i].r16));
      check({"vec ", vecs[i].text, " result8"}, 64'(res8),   64'(vecs[i].r8));
    end

    // Random expressions, mostly legal, occasionally junk, with random idle gaps.
    for (int t = 0; t < 300; t++) begin
      int    len;
      string alpha;
      alpha = "0123456789+*()";
      len = $urandom_range(1, 14);
      pulse_clr();
      for (int i = 0; i < len; i++) begin
        logic [7:0] c;
        c = alpha[$urandom_range(0, 13)];
        if ($urandom_range(0, 9) != 0) begin
          for (int k = 0; k < 20 && !legal_next(mq, c); k++)
            c = alpha[$urandom_range(0, 13)];
        end else begin
          c = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 4) == 0) gap($urandom_range(1, 2));
        send(c);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
